key_event_decoder: RTL
======================

// Module: key_event_decoder
// PURPOSE
//   Consumes the debounced, synchronised key level and classifies each gesture as a short
//   press, long press or double click. Output is one single-cycle event pulse per gesture.
//   Sits downstream of the key debouncer and feeds mode/menu FSMs in the 12 MHz user-I/O path.
// PARAMETERS
//   LONG_CYC    12_000_000  cycles key must stay low to count as a long press (1 s @12 MHz)
//   DCLICK_CYC   3_600_000  max release gap before a second press (300 ms @12 MHz)
//   REPEAT_CYC   1_200_000  auto-repeat period while held after a long press (KEY_REPEAT_EN only)
//   CNT_W              24  counter width; must satisfy 2**CNT_W > max(LONG_CYC, DCLICK_CYC)
// PORTS
//   clk       in   1  system clock
//   rst       in   1  asynchronous reset, active-high
//   key_n     in   1  debounced key level, active-low (0 = pressed), already synchronous to clk
//   short_p   out  1  one-cycle pulse: single short press completed
//   long_p    out  1  one-cycle pulse: key held LONG_CYC cycles
//   double_p  out  1  one-cycle pulse: double click completed
//   repeat_p  out  1  one-cycle pulse: auto-repeat tick (tied 0 without KEY_REPEAT_EN)
//   busy      out  1  high whenever state != IDLE
// BEHAVIOUR
//   - Reset: all pulse outputs 0 and cnt=0; state=ARM, so busy=1 during reset.
//   - Outputs are registered. At most one pulse output is high in any cycle.
//   - One counter cnt[CNT_W-1:0] is cleared on every state transition and increments otherwise.
//   - "Sampled" means key_n as seen at a rising clk edge.
//   - ARM:    wait for key_n==1, then go to IDLE. This stops a key held through reset from
//             producing an event.
//   - IDLE:   key_n==0 -> PRESS1.
//   - PRESS1: key_n==1 before timeout -> GAP.
//             cnt==LONG_CYC-1 with key_n==0 -> assert long_p, go to HELD.
//   - GAP:    key_n==0 -> PRESS2.
//             cnt==DCLICK_CYC-1 with key_n==1 -> assert short_p, go to IDLE.
//   - PRESS2: key_n==1 -> assert double_p, go to IDLE.
//             cnt==LONG_CYC-1 with key_n==0 -> assert long_p, go to HELD; no double_p.
//   - HELD:   key_n==1 -> IDLE, no pulse.
//   - Timing: long_p is high in the cycle starting exactly LONG_CYC edges after the edge that
//     first sampled key_n==0 in IDLE/GAP.
//   - Timing: short_p is high DCLICK_CYC edges after the edge that first sampled the release.
//   - Timing: double_p is high the cycle after the edge sampling the second release.
//   - Simultaneous release and timeout in the same cycle:
//       PRESS1/PRESS2: release wins (the press counts as short).
//       GAP: timeout wins only if key_n==1; key_n==0 always goes to PRESS2.
//   - A third press inside the gap after a double click is not special: it starts a new
//     PRESS1 from IDLE.
//   - Counter saturates at its terminal value (no wrap) in any state that lacks a timeout.
//   - Asserting rst mid-gesture drops the gesture silently and returns to ARM.
// CONFIGURATION
//   KEY_REPEAT_EN defined:
//     - In HELD, repeat_p pulses every REPEAT_CYC cycles while key_n==0.
//     - First repeat_p comes REPEAT_CYC cycles after long_p.
//     - cnt is reloaded to 0 on each pulse.
//   KEY_REPEAT_EN undefined:
//     - repeat_p is constant 0.
//     - No repeat logic is synthesised; HELD only waits for release.
// TESTING  (bench params LONG_CYC=20, DCLICK_CYC=10, REPEAT_CYC=5)
//   - key_n low 5 cycles, then high 15 -> short_p once, 10 cycles after release edge; others 0.
//   - key_n low 25 cycles -> long_p once at cycle 20 after press; no pulse on release.
//   - Low 4, high 3, low 4, high -> double_p the cycle after second release; short_p stays 0.
//   - key_n held low through rst deassert, released at cycle 8, pressed 3 short -> only one
//     short_p, from the later press.
//   - KEY_REPEAT_EN: hold 36 cycles -> long_p @20, repeat_p @25,30,35.
//     Without KEY_REPEAT_EN: repeat_p stays 0.
//   - rst pulsed during GAP (cycle 3 of gap) -> no short_p; busy=1 until key_n seen high.

Source files
------------

// File: rtl/key_event_decoder.sv
// Key gesture classifier: short press, long press and double click from a debounced active-low key.
// Optional auto-repeat while held after a long press is built when KEY_REPEAT_EN is defined.
module key_event_decoder #(
  parameter int unsigned LONG_CYC   = 12_000_000,
  parameter int unsigned DCLICK_CYC = 3_600_000,
`ifdef KEY_REPEAT_EN
  parameter int unsigned REPEAT_CYC = 1_200_000,
`endif
  parameter int unsigned CNT_W      = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic short_p,
  output logic long_p,
  output logic double_p,
  output logic repeat_p,
  output logic busy
);

  typedef enum logic [2:0] {
    S_ARM    = 3'd0,
    S_IDLE   = 3'd1,
    S_PRESS1 = 3'd2,
    S_GAP    = 3'd3,
    S_PRESS2 = 3'd4,
    S_HELD   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_short;
  logic             r_long;
  logic             r_double;
  logic             r_busy;
  logic [CNT_W-1:0] w_cnt_inc;

  // Saturating increment: states without a timeout simply park at all-ones.
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

`ifdef KEY_REPEAT_EN
  logic r_repeat;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_ARM;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_busy   <= 1'b1;
`ifdef KEY_REPEAT_EN
      r_repeat <= 1'b0;
`endif
    end else begin
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_repeat <= 1'b0;
`endif
      r_cnt    <= w_cnt_inc;
      case (r_state)
        // A key held through reset must be released before anything is recognised.
        S_ARM: begin
          if (key_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (!key_n) begin
            r_state <= S_PRESS1;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        // Release is tested first so it wins over a coincident long timeout.
        S_PRESS1: begin
          if (key_n) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
          end else if (r_cnt == LONG_LAST) begin
            r_long  <= 1'b1;
            r_state <= S_HELD;
            r_cnt   <= '0;
          end
        end
        S_GAP: begin
          if (!key_n) begin
            r_state <= S_PRESS2;
            r_cnt   <= '0;
          end else if (r_cnt == DCLICK_LAST) begin
            r_short <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        S_PRESS2: begin
          if (key_n) begin
            r_double <= 1'b1;
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
          end else if (r_cnt == LONG_LAST) begin
            r_long  <= 1'b1;
            r_state <= S_HELD;
            r_cnt   <= '0;
          end
        end
        S_HELD: begin
          if (key_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
`ifdef KEY_REPEAT_EN
          else if (r_cnt == REPEAT_LAST) begin
            r_repeat <= 1'b1;
            r_cnt    <= '0;
          end
`endif
        end
        default: begin
          r_state <= S_ARM;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign short_p  = r_short;
  assign long_p   = r_long;
  assign double_p = r_double;
  assign busy     = r_busy;
`ifdef KEY_REPEAT_EN
  assign repeat_p = r_repeat;
`else
  assign repeat_p = 1'b0;
`endif

endmodule
